// File: rtl/dmem_responder.sv
// Multi-cycle byte-addressed data memory slave with valid/ready request and response channels.
// Define DMEM_RESPONDER_DEBUG_EN to expose dbg_dword0..7, a dword view of the first 64 bytes.
module dmem_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_rdata,
    output logic        rsp_err
`ifdef DMEM_RESPONDER_DEBUG_EN
    ,
    output logic [63:0] dbg_dword0,
    output logic [63:0] dbg_dword1,
    output logic [63:0] dbg_dword2,
    output logic [63:0] dbg_dword3,
    output logic [63:0] dbg_dword4,
    output logic [63:0] dbg_dword5,
    output logic [63:0] dbg_dword6,
    output logic [63:0] dbg_dword7
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    typedef struct packed {
        logic        write;
        logic [2:0]  funct3;
        logic [63:0] addr;
        logic [63:0] wdata;
    } req_t;

    state_t              state, state_nxt;
    req_t                req_q;
    logic [CW-1:0]       cnt;
    logic [7:0]          mem [DEPTH];

    logic                do_access;
    logic [7:0]          bmask;
    logic [2:0]          amask;
    logic [3:0]          nbytes;
    logic [7:0][AW-1:0]  bidx;
    logic [64:0]         end_addr;
    logic                misalign, oor, illegal, sx;
    logic [63:0]         raw, ext;
    logic                acc_err;
    logic [63:0]         acc_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            req_q     <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && req_valid) begin
                req_q <= '{write: req_write, funct3: req_funct3, addr: req_addr, wdata: req_wdata};
                cnt   <= CW'(LATENCY - 1);
            end
            if (state == BUSY) begin
                if (cnt != '0) begin
                    cnt <= cnt - CW'(1);
                end else begin
                    rsp_rdata <= acc_rdata;
                    rsp_err   <= acc_err;
                end
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_valid) state_nxt = BUSY;
            BUSY:    if (cnt == '0) state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state == IDLE);
        rsp_valid = (state == RESP);
        do_access = (state == BUSY) && (cnt == '0);
    end

    // Range check runs in 65 bits so an address near 2^64 cannot wrap into range.
    always_comb begin
        case (req_q.funct3[1:0])
            2'b00:   begin bmask = 8'h01; amask = 3'b000; nbytes = 4'd1; end
            2'b01:   begin bmask = 8'h03; amask = 3'b001; nbytes = 4'd2; end
            2'b10:   begin bmask = 8'h0F; amask = 3'b011; nbytes = 4'd4; end
            default: begin bmask = 8'hFF; amask = 3'b111; nbytes = 4'd8; end
        endcase
        misalign = |(req_q.addr[2:0] & amask);
        end_addr = {1'b0, req_q.addr} + {61'd0, nbytes};
        oor      = end_addr > 65'(DEPTH);
        illegal  = req_q.write ? req_q.funct3[2] : (req_q.funct3 == 3'b111);
        acc_err  = misalign | oor | illegal;

        bidx = '0;
        raw  = '0;
        for (int i = 0; i < 8; i++) begin
            bidx[i] = req_q.addr[AW-1:0] + AW'(i);
            if (bmask[i]) raw[8*i +: 8] = mem[bidx[i]];
        end

        sx = ~req_q.funct3[2];
        case (req_q.funct3[1:0])
            2'b00:   ext = {{56{sx & raw[7]}},  raw[7:0]};
            2'b01:   ext = {{48{sx & raw[15]}}, raw[15:0]};
            2'b10:   ext = {{32{sx & raw[31]}}, raw[31:0]};
            default: ext = raw;
        endcase
        acc_rdata = (acc_err || req_q.write) ? 64'd0 : ext;
    end

    // Storage has no reset; a reset on the commit edge drops the store.
    always_ff @(posedge clk) begin
        if (!reset && do_access && req_q.write && !acc_err) begin
            for (int i = 0; i < 8; i++) begin
                if (bmask[i]) mem[bidx[i]] <= req_q.wdata[8*i +: 8];
            end
        end
    end

`ifdef DMEM_RESPONDER_DEBUG_EN
    logic [7:0][63:0] dbg_view;

    for (genvar k = 0; k < 8; k++) begin : g_dbg
        for (genvar b = 0; b < 8; b++) begin : g_byte
            if (8*k + b < DEPTH) begin : g_in
                assign dbg_view[k][8*b +: 8] = mem[8*k + b];
            end else begin : g_out
                assign dbg_view[k][8*b +: 8] = 8'h00;
            end
        end
    end

    assign dbg_dword0 = dbg_view[0];
    assign dbg_dword1 = dbg_view[1];
    assign dbg_dword2 = dbg_view[2];
    assign dbg_dword3 = dbg_view[3];
    assign dbg_dword4 = dbg_view[4];
    assign dbg_dword5 = dbg_view[5];
    assign dbg_dword6 = dbg_view[6];
    assign dbg_dword7 = dbg_view[7];
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: instance 0 at LATENCY=2, 1 at LATENCY=4, 2 at LATENCY=1.
module tb_dmem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        reset      [3];
    logic        req_valid  [3];
    logic        req_ready  [3];
    logic        req_write  [3];
    logic [2:0]  req_funct3 [3];
    logic [63:0] req_addr   [3];
    logic [63:0] req_wdata  [3];
    logic        rsp_valid  [3];
    logic        rsp_ready  [3];
    logic [63:0] rsp_rdata  [3];
    logic        rsp_err    [3];
`ifdef DMEM_RESPONDER_DEBUG_EN
    logic [63:0] dbg [3][8];
`endif

    for (genvar g = 0; g < 3; g++) begin : g_dut
        dmem_responder #(
            .DEPTH   (256),
            .LATENCY (g == 0 ? 2 : (g == 1 ? 4 : 1))
        ) u_dut (
            .clk        (clk),
            .reset      (reset[g]),
            .req_valid  (req_valid[g]),
            .req_ready  (req_ready[g]),
            .req_write  (req_write[g]),
            .req_funct3 (req_funct3[g]),
            .req_addr   (req_addr[g]),
            .req_wdata  (req_wdata[g]),
            .rsp_valid  (rsp_valid[g]),
            .rsp_ready  (rsp_ready[g]),
            .rsp_rdata  (rsp_rdata[g]),
            .rsp_err    (rsp_err[g])
`ifdef DMEM_RESPONDER_DEBUG_EN
            ,
            .dbg_dword0 (dbg[g][0]),
            .dbg_dword1 (dbg[g][1]),
            .dbg_dword2 (dbg[g][2]),
            .dbg_dword3 (dbg[g][3]),
            .dbg_dword4 (dbg[g][4]),
            .dbg_dword5 (dbg[g][5]),
            .dbg_dword6 (dbg[g][6]),
            .dbg_dword7 (dbg[g][7])
`endif
        );
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timed out waiting on DUT", name);
    endtask

    // One full transaction with rsp_ready held high; lat = edges from accept to rsp_valid.
    task automatic txn(input int k, input logic wr, input logic [2:0] f3, input logic [63:0] a,
                       input logic [63:0] wd, output logic [63:0] rd, output logic er, output int lat);
        int n;
        @(negedge clk);
        req_valid[k] = 1'b1; req_write[k] = wr; req_funct3[k] = f3;
        req_addr[k] = a; req_wdata[k] = wd; rsp_ready[k] = 1'b1;
        n = 0;
        while (!req_ready[k] && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) timeout("txn_accept");
        @(posedge clk);
        @(negedge clk);
        req_valid[k] = 1'b0;
        lat = 0;
        while (!rsp_valid[k] && lat < 50) begin @(posedge clk); lat++; @(negedge clk); end
        rd = rsp_rdata[k];
        er = rsp_err[k];
        @(posedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        logic        wr;
        logic [2:0]  f3;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] exp_rd;
        logic        exp_err;
        string       name;
    } vec_t;

    function automatic vec_t mk(input logic wr, input logic [2:0] f3, input logic [63:0] addr,
                                input logic [63:0] wdata, input logic [63:0] exp_rd,
                                input logic exp_err, input string name);
        vec_t v;
        v.wr = wr; v.f3 = f3; v.addr = addr; v.wdata = wdata;
        v.exp_rd = exp_rd; v.exp_err = exp_err; v.name = name;
        return v;
    endfunction

    vec_t        vecs [22];
    logic [63:0] rd;
    logic        er;
    int          lat;
    int          acc_c [4];
    logic [63:0] got   [4];
    logic [63:0] dat   [4];
    int          na, nr, n;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = mk(1, 3'b011, 64'h10,  64'h1122334455667788, 64'h0, 0, "sd_10");
        vecs[1]  = mk(0, 3'b011, 64'h10,  64'h0, 64'h1122334455667788, 0, "ld_10");
        vecs[2]  = mk(1, 3'b000, 64'h20,  64'h80, 64'h0, 0, "sb_20");
        vecs[3]  = mk(0, 3'b000, 64'h20,  64'h0, 64'hFFFFFFFFFFFFFF80, 0, "lb_20");
        vecs[4]  = mk(0, 3'b100, 64'h20,  64'h0, 64'h0000000000000080, 0, "lbu_20");
        vecs[5]  = mk(0, 3'b001, 64'h16,  64'h0, 64'h0000000000001122, 0, "lh_16");
        vecs[6]  = mk(0, 3'b001, 64'h14,  64'h0, 64'h0000000000003344, 0, "lh_14");
        vecs[7]  = mk(0, 3'b010, 64'h10,  64'h0, 64'h0000000055667788, 0, "lw_10");
        vecs[8]  = mk(1, 3'b011, 64'hF8,  64'hDEADBEEFCAFEF00D, 64'h0, 0, "sd_f8");
        vecs[9]  = mk(0, 3'b010, 64'hF8,  64'h0, 64'hFFFFFFFFCAFEF00D, 0, "lw_f8");
        vecs[10] = mk(0, 3'b110, 64'hF8,  64'h0, 64'h00000000CAFEF00D, 0, "lwu_f8");
        vecs[11] = mk(0, 3'b000, 64'hFF,  64'h0, 64'hFFFFFFFFFFFFFFDE, 0, "lb_last_byte");
        vecs[12] = mk(0, 3'b010, 64'h12,  64'h0, 64'h0, 1, "lw_misaligned");
        vecs[13] = mk(1, 3'b011, 64'hFC,  64'h0123456789ABCDEF, 64'h0, 1, "sd_out_of_range");
        vecs[14] = mk(1, 3'b100, 64'hF8,  64'h5555555555555555, 64'h0, 1, "st_illegal");
        vecs[15] = mk(0, 3'b111, 64'h10,  64'h0, 64'h0, 1, "ld_illegal");
        vecs[16] = mk(0, 3'b011, 64'hFFFFFFFFFFFFFFF8, 64'h0, 64'h0, 1, "ld_wrap_addr");
        vecs[17] = mk(0, 3'b000, 64'h100, 64'h0, 64'h0, 1, "lb_at_depth");
        vecs[18] = mk(0, 3'b011, 64'hF8,  64'h0, 64'hDEADBEEFCAFEF00D, 0, "ld_f8_unchanged");
        vecs[19] = mk(1, 3'b001, 64'h22,  64'hBEEF, 64'h0, 0, "sh_22");
        vecs[20] = mk(0, 3'b001, 64'h22,  64'h0, 64'hFFFFFFFFFFFFBEEF, 0, "lh_22");
        vecs[21] = mk(0, 3'b101, 64'h22,  64'h0, 64'h000000000000BEEF, 0, "lhu_22");

        for (int k = 0; k < 3; k++) begin
            reset[k] = 1'b1; req_valid[k] = 1'b0; req_write[k] = 1'b0; req_funct3[k] = 3'b0;
            req_addr[k] = '0; req_wdata[k] = '0; rsp_ready[k] = 1'b0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) reset[k] = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk("rst_req_ready", 64'(req_ready[k]), 64'd1);
            chk("rst_rsp_valid", 64'(rsp_valid[k]), 64'd0);
            chk("rst_rsp_rdata", rsp_rdata[k], 64'd0);
            chk("rst_rsp_err",   64'(rsp_err[k]), 64'd0);
        end

        for (int i = 0; i < 22; i++) begin
            txn(0, vecs[i].wr, vecs[i].f3, vecs[i].addr, vecs[i].wdata, rd, er, lat);
            chk({vecs[i].name, "_rdata"}, rd, vecs[i].exp_rd);
            chk({vecs[i].name, "_err"}, 64'(er), 64'(vecs[i].exp_err));
            chk({vecs[i].name, "_latency"}, 64'(lat), 64'd2);
        end

        // Backpressure: a store presented while busy must never be taken.
        @(negedge clk);
        req_valid[0] = 1'b1; req_write[0] = 1'b0; req_funct3[0] = 3'b011;
        req_addr[0] = 64'h10; rsp_ready[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_write[0] = 1'b1; req_wdata[0] = 64'hAAAAAAAAAAAAAAAA;
        n = 0;
        while (!rsp_valid[0] && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) timeout("bp_rsp_valid");
        for (int c = 0; c < 5; c++) begin
            chk("bp_rsp_valid", 64'(rsp_valid[0]), 64'd1);
            chk("bp_rsp_rdata", rsp_rdata[0], 64'h1122334455667788);
            chk("bp_req_ready", 64'(req_ready[0]), 64'd0);
            @(negedge clk);
        end
        req_valid[0] = 1'b0; rsp_ready[0] = 1'b1;
        @(negedge clk);
        chk("bp_release_rsp_valid", 64'(rsp_valid[0]), 64'd0);
        chk("bp_release_req_ready", 64'(req_ready[0]), 64'd1);
        txn(0, 0, 3'b011, 64'h10, 64'h0, rd, er, lat);
        chk("bp_store_not_taken", rd, 64'h1122334455667788);

        // Reset while a committed store sits in RESP keeps the data.
        txn(0, 1, 3'b000, 64'h40, 64'h11, rd, er, lat);
        @(negedge clk);
        req_valid[0] = 1'b1; req_write[0] = 1'b1; req_funct3[0] = 3'b000;
        req_addr[0] = 64'h40; req_wdata[0] = 64'h77; rsp_ready[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_valid[0] = 1'b0;
        n = 0;
        while (!rsp_valid[0] && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) timeout("rst_resp_valid");
        reset[0] = 1'b1;
        @(negedge clk);
        reset[0] = 1'b0;
        chk("rst_resp_rsp_valid", 64'(rsp_valid[0]), 64'd0);
        chk("rst_resp_req_ready", 64'(req_ready[0]), 64'd1);
        txn(0, 0, 3'b100, 64'h40, 64'h0, rd, er, lat);
        chk("rst_resp_store_kept", rd, 64'h77);

        // LATENCY=4: reset one cycle after accepting a store discards it.
        txn(1, 1, 3'b000, 64'h30, 64'h5A, rd, er, lat);
        chk("l4_latency", 64'(lat), 64'd4);
        @(negedge clk);
        req_valid[1] = 1'b1; req_write[1] = 1'b1; req_funct3[1] = 3'b000;
        req_addr[1] = 64'h30; req_wdata[1] = 64'hAA; rsp_ready[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid[1] = 1'b0;
        reset[1] = 1'b1;
        @(negedge clk);
        reset[1] = 1'b0;
        chk("rst_busy_rsp_valid", 64'(rsp_valid[1]), 64'd0);
        chk("rst_busy_req_ready", 64'(req_ready[1]), 64'd1);
        n = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (rsp_valid[1]) n++;
        end
        chk("rst_busy_no_late_rsp", 64'(n), 64'd0);
        txn(1, 0, 3'b100, 64'h30, 64'h0, rd, er, lat);
        chk("rst_busy_store_dropped", rd, 64'h5A);

        // LATENCY=1 back-to-back loads with req_valid and rsp_ready held high.
        for (int i = 0; i < 4; i++) begin
            dat[i] = {8{8'(8'h10 + i)}};
            txn(2, 1, 3'b011, 64'(8 * i), dat[i], rd, er, lat);
            chk("l1_store_latency", 64'(lat), 64'd1);
        end
        req_write[2] = 1'b0; req_funct3[2] = 3'b011; rsp_ready[2] = 1'b1;
        na = 0; nr = 0;
        for (int c = 0; c < 60 && nr < 4; c++) begin
            @(negedge clk);
            if (c == 0) req_valid[2] = 1'b1;
            if (rsp_valid[2]) begin got[nr] = rsp_rdata[2]; nr++; end
            if (req_ready[2]) begin
                if (na < 4) begin
                    req_addr[2] = 64'(8 * na);
                    acc_c[na] = cyc;
                    na++;
                end else begin
                    req_valid[2] = 1'b0;
                end
            end
        end
        req_valid[2] = 1'b0;
        if (nr < 4) timeout("l1_b2b_responses");
        // Accept edges sit LATENCY+2 apart: BUSY and RESP leave req_ready low for LATENCY+1 cycles.
        for (int i = 0; i < 3; i++) chk("l1_accept_gap", 64'(acc_c[i+1] - acc_c[i]), 64'd3);
        for (int i = 0; i < 4; i++) chk("l1_rsp_order", got[i], dat[i]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
